// File: rtl/spart_pkg.sv
// Shared types and helpers for the SPART transmit/receive paths.
package spart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int unsigned MAX_DATA_BITS = 9;

   function automatic int unsigned sub_cnt_w(input int unsigned oversample);
      return (oversample < 2) ? 1 : $clog2(oversample);
   endfunction

   function automatic int unsigned bit_cnt_w(input int unsigned data_bits);
      return (data_bits < 2) ? 1 : $clog2(data_bits);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Zero padding above the real data bits leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/spart_fifo.sv
// Small synchronous FIFO with occupancy count; shared by the SPART tx and rx paths.
module spart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: FIFO-buffered asynchronous serialiser timed by an oversampled baud strobe.
module spart_tx_fifo
   import spart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          wr_en,
   input  logic [DATA_BITS-1:0]          wr_data,
   output logic                          full,
   output logic                          tbr,
   output logic                          tx_idle,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          tx
);

   localparam int unsigned SW = sub_cnt_w(OVERSAMPLE);
   localparam int unsigned BW = bit_cnt_w(DATA_BITS);

   tx_state_t                state;
   logic [SW-1:0]            sub_cnt;
   logic [BW-1:0]            bit_cnt;
   logic [DATA_BITS-1:0]     shreg;
   logic                     par_bit;
   logic [DATA_BITS-1:0]     head;
   logic [MAX_DATA_BITS-1:0] head_pad;
   logic                     head_par;
   logic                     empty;
   logic                     pop;
   logic                     bit_end;
   logic                     last_stop;

   spart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

   always_comb begin
      head_pad = '0;
      head_pad[DATA_BITS-1:0] = head;
   end

   assign head_par  = calc_parity(head_pad, PARITY_ODD != 0);
   assign bit_end   = enable && (sub_cnt == SW'(OVERSAMPLE - 1));
   assign last_stop = bit_end && (bit_cnt == BW'(STOP_BITS - 1));
   // Pop from IDLE, or at the end of the last stop bit so frames run back-to-back.
   assign pop       = !empty && ((state == IDLE) || ((state == STOP) && last_stop));
   assign tbr       = !full;
   assign tx_idle   = empty && (state == IDLE);

   // tx is registered from the next state, so it always reflects the bit being sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sub_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
      end else begin
         if (enable && (state != IDLE)) sub_cnt <= bit_end ? '0 : sub_cnt + SW'(1);
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shreg   <= head;
                  par_bit <= head_par;
                  state   <= START;
                  tx      <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_EN != 0) ? PARITY : STOP;
                     tx      <= (PARITY_EN != 0) ? par_bit : 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     tx      <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= STOP;
                  tx      <= 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     bit_cnt <= '0;
                     if (pop) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        state   <= START;
                        tx      <= 1'b0;
                     end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                overflow <= 1'b0;
      else if (wr_en && full)    overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
   end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Directed bench for spart_tx_fifo: four configurations, frame tables plus FIFO/reset sequences.
module tb_spart_tx_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]       wr;
   logic [3:0]       clr;
   logic [7:0]       wd0, wd1, wd2;
   logic [4:0]       wd3;
   logic             en0, en2;
   logic [3:0]       full_v, tbr_v, idle_v, ovf_v, tx_v;
   logic [3:0][2:0]  cnt_v;
   int               ph;

   int n_run  = 0;
   int n_fail = 0;

   logic s [0:255];

   typedef struct {
      int          d;
      logic [7:0]  data;
      logic [11:0] exp;      // line bits, index 0 = start bit
      int          nbits;
      int          period;
      int          slack;    // allowed shortfall of the start bit (enable phase)
   } vec_t;
   vec_t vecs [6];

   // dut0: defaults, OVERSAMPLE=4, enable controllable
   spart_tx_fifo #(.OVERSAMPLE(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .wr_en(wr[0]), .wr_data(wd0),
      .full(full_v[0]), .tbr(tbr_v[0]), .tx_idle(idle_v[0]), .fifo_count(cnt_v[0]),
      .overflow(ovf_v[0]), .ovf_clr(clr[0]), .tx(tx_v[0])
   );
   // dut1: even parity, two stop bits
   spart_tx_fifo #(.OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .wr_en(wr[1]), .wr_data(wd1),
      .full(full_v[1]), .tbr(tbr_v[1]), .tx_idle(idle_v[1]), .fifo_count(cnt_v[1]),
      .overflow(ovf_v[1]), .ovf_clr(clr[1]), .tx(tx_v[1])
   );
   // dut2: odd parity, OVERSAMPLE=16 with enable one cycle in three
   spart_tx_fifo #(.OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .wr_en(wr[2]), .wr_data(wd2),
      .full(full_v[2]), .tbr(tbr_v[2]), .tx_idle(idle_v[2]), .fifo_count(cnt_v[2]),
      .overflow(ovf_v[2]), .ovf_clr(clr[2]), .tx(tx_v[2])
   );
   // dut3: five data bits
   spart_tx_fifo #(.DATA_BITS(5), .OVERSAMPLE(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable(1'b1), .wr_en(wr[3]), .wr_data(wd3),
      .full(full_v[3]), .tbr(tbr_v[3]), .tx_idle(idle_v[3]), .fifo_count(cnt_v[3]),
      .overflow(ovf_v[3]), .ovf_clr(clr[3]), .tx(tx_v[3])
   );

   initial begin
      ph  = 0;
      en2 = 1'b0;
      forever begin
         @(negedge clk);
         ph  = (ph == 2) ? 0 : ph + 1;
         en2 = (ph == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [7:0] v);
      @(negedge clk);
      case (d)
         0:       wd0 = v;
         1:       wd1 = v;
         2:       wd2 = v;
         default: wd3 = v[4:0];
      endcase
      wr[d] = 1'b1;
      @(negedge clk);
      wr[d] = 1'b0;
   endtask

   task automatic wait_start(input int d, input string name);
      int n;
      n = 0;
      while (tx_v[d] !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({name, " start timeout"}, 32'(tx_v[d]), 32'd0);
   endtask

   task automatic wait_idle(input int d, input string name);
      int n;
      n = 0;
      while (idle_v[d] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, " reaches idle"}, 32'(idle_v[d]), 32'd1);
   endtask

   task automatic check_frame(input int d, input logic [11:0] exp, input int nbits,
                              input int period, input int slack, input string name);
      int   run;
      logic ok;
      logic pre;
      wait_start(d, name);
      ok  = 1'b1;
      pre = 1'b0;
      if (slack == 0) begin
         for (int i = 0; i < period; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_v[d] !== exp[0]) ok = 1'b0;
         end
      end else begin
         run = 0;
         while (tx_v[d] === 1'b0 && run < period + 4) begin
            @(negedge clk);
            run++;
         end
         if (run < period - slack || run > period) ok = 1'b0;
         pre = 1'b1;
      end
      check($sformatf("%s start bit", name), 32'(ok), 32'd1);
      for (int b = 1; b < nbits; b++) begin
         ok = 1'b1;
         for (int i = 0; i < period; i++) begin
            if (!(pre && b == 1 && i == 0)) @(negedge clk);
            if (tx_v[d] !== exp[b]) ok = 1'b0;
         end
         check($sformatf("%s bit %0d", name, b), 32'(ok), 32'd1);
      end
      @(negedge clk);
      check($sformatf("%s idle after frame", name), 32'(idle_v[d]), 32'd1);
   endtask

   // Frame of dut0 recorded in s[] starting at base, 4 samples per bit.
   task automatic decode_frame(input int base, input logic [7:0] w, input string name);
      logic [9:0] e;
      logic       ok;
      e  = {1'b1, w, 1'b0};
      ok = 1'b1;
      for (int b = 0; b < 10; b++)
         for (int i = 0; i < 4; i++)
            if (s[base + 4 * b + i] !== e[b]) ok = 1'b0;
      check(name, 32'(ok), 32'd1);
   endtask

   initial begin
      int   run;
      logic ok;
      wr = '0; clr = '0; wd0 = '0; wd1 = '0; wd2 = '0; wd3 = '0; en0 = 1'b1;
      vecs[0] = '{0, 8'hA5, 12'h34A, 10, 4, 0};
      vecs[1] = '{0, 8'h3C, 12'h278, 10, 4, 0};
      vecs[2] = '{1, 8'hA5, 12'hD4A, 12, 4, 0};
      vecs[3] = '{1, 8'h00, 12'hC00, 12, 4, 0};
      vecs[4] = '{2, 8'hA5, 12'h74A, 11, 48, 2};
      vecs[5] = '{3, 8'h13, 12'h066, 7, 4, 0};

      repeat (3) @(negedge clk);
      check("reset tx", 32'(tx_v), 32'hF);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset tx_idle", 32'(idle_v), 32'hF);
      check("reset full", 32'(full_v), 32'h0);
      check("reset tbr", 32'(tbr_v), 32'hF);
      check("reset overflow", 32'(ovf_v), 32'h0);
      check("reset count", 32'(cnt_v[0]), 32'd0);

      for (int v = 0; v < 6; v++) begin
         push(vecs[v].d, vecs[v].data);
         check_frame(vecs[v].d, vecs[v].exp, vecs[v].nbits, vecs[v].period, vecs[v].slack,
                     $sformatf("vec%0d", v));
      end

      // Stall enable for 100 clk in the middle of data bit 1 of 0x55.
      push(0, 8'h55);
      wait_start(0, "stall");
      repeat (9) @(negedge clk);
      check("stall bit1 level", 32'(tx_v[0]), 32'd0);
      en0 = 1'b0;
      ok  = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (tx_v[0] !== 1'b0) ok = 1'b0;
      end
      check("stall holds bit", 32'(ok), 32'd1);
      en0 = 1'b1;
      run = 0;
      @(negedge clk);
      while (tx_v[0] === 1'b0 && run < 10) begin
         run++;
         @(negedge clk);
      end
      check("stall remainder", 32'(run), 32'd2);
      run = 1;
      @(negedge clk);
      while (tx_v[0] === 1'b1 && run < 10) begin
         run++;
         @(negedge clk);
      end
      check("bit after stall", 32'(run), 32'd4);
      wait_idle(0, "stall");

      // Five pushes while idle, then a sixth rejected push with ovf_clr (set wins).
      @(negedge clk); wr[0] = 1'b1; wd0 = 8'h01;
      @(negedge clk); wd0 = 8'h02;
      @(negedge clk); s[0] = tx_v[0]; wd0 = 8'h03;
      @(negedge clk); s[1] = tx_v[0]; wd0 = 8'h04;
      @(negedge clk); s[2] = tx_v[0]; wd0 = 8'h05;
      @(negedge clk); s[3] = tx_v[0];
      check("fifo5 full", 32'(full_v[0]), 32'd1);
      check("fifo5 count", 32'(cnt_v[0]), 32'd4);
      check("fifo5 no overflow yet", 32'(ovf_v[0]), 32'd0);
      wd0 = 8'h06; clr[0] = 1'b1;
      @(negedge clk); s[4] = tx_v[0]; wr[0] = 1'b0; clr[0] = 1'b0;
      check("overflow set wins", 32'(ovf_v[0]), 32'd1);
      check("rejected push count", 32'(cnt_v[0]), 32'd4);
      check("tbr while full", 32'(tbr_v[0]), 32'd0);
      for (int k = 5; k <= 200; k++) begin
         @(negedge clk);
         s[k] = tx_v[0];
      end
      check("fifo5 idle after 5 frames", 32'(idle_v[0]), 32'd1);
      for (int f = 0; f < 5; f++) decode_frame(40 * f, 8'(f + 1), $sformatf("fifo5 frame%0d", f));

      // Push coincides with the pop at the end of a stop bit while count is 2.
      @(negedge clk); wr[0] = 1'b1; wd0 = 8'h11;
      @(negedge clk); wd0 = 8'h22;
      @(negedge clk); s[0] = tx_v[0]; wd0 = 8'h33;
      @(negedge clk); s[1] = tx_v[0]; wr[0] = 1'b0;
      check("pushpop count before", 32'(cnt_v[0]), 32'd2);
      for (int k = 2; k <= 39; k++) begin
         @(negedge clk);
         s[k] = tx_v[0];
      end
      wr[0] = 1'b1; wd0 = 8'h44;
      @(negedge clk); s[40] = tx_v[0]; wr[0] = 1'b0;
      check("pushpop count same", 32'(cnt_v[0]), 32'd2);
      for (int k = 41; k <= 160; k++) begin
         @(negedge clk);
         s[k] = tx_v[0];
      end
      check("pushpop idle", 32'(idle_v[0]), 32'd1);
      decode_frame(0, 8'h11, "pushpop frame0");
      decode_frame(40, 8'h22, "pushpop frame1");
      decode_frame(80, 8'h33, "pushpop frame2");
      decode_frame(120, 8'h44, "pushpop frame3");

      // Asynchronous reset during data bit 3, with one word queued and overflow set.
      @(negedge clk); wr[0] = 1'b1; wd0 = 8'h00;
      @(negedge clk);
      @(negedge clk); wr[0] = 1'b0;
      repeat (18) @(negedge clk);
      check("pre-reset tx low", 32'(tx_v[0]), 32'd0);
      check("pre-reset count", 32'(cnt_v[0]), 32'd1);
      check("pre-reset overflow", 32'(ovf_v[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid-frame reset tx", 32'(tx_v[0]), 32'd1);
      check("mid-frame reset count", 32'(cnt_v[0]), 32'd0);
      check("mid-frame reset overflow", 32'(ovf_v[0]), 32'd0);
      check("mid-frame reset idle", 32'(idle_v[0]), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (tx_v[0] !== 1'b1) ok = 1'b0;
      end
      check("no residual frame", 32'(ok), 32'd1);

      // Overflow and ovf_clr on dut1.
      @(negedge clk); wr[1] = 1'b1; wd1 = 8'h81;
      repeat (6) @(negedge clk);
      wr[1] = 1'b0;
      check("dut1 full", 32'(full_v[1]), 32'd1);
      check("dut1 overflow", 32'(ovf_v[1]), 32'd1);
      clr[1] = 1'b1;
      @(negedge clk); clr[1] = 1'b0;
      check("dut1 overflow cleared", 32'(ovf_v[1]), 32'd0);
      wait_idle(1, "dut1 drain");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/spart_tx_fifo.md
Name: spart_tx_fifo

Overview:
Parametrised successor to the SPART transmitter. It accepts words from the bus side into a small transmit FIFO and serialises them onto a single line. Frames are asynchronous: start bit, DATA_BITS data bits sent LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from an external oversampled baud `enable` strobe, and consecutive frames are sent back-to-back.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, `enable` pulses per bit period; legal range 2..32.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  baud strobe at OVERSAMPLE x bit rate; one clk wide.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  DATA_BITS  word to transmit.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- tbr  out  1  transmit buffer ready; equal to !full.
- tx_idle  out  1  FIFO is empty and the FSM is in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- overflow  out  1  sticky flag: a push was dropped.
- ovf_clr  in  1  clears overflow.
- tx  out  1  serial output; registered; idles high.

Behaviour:
- Reset (asynchronous, takes effect mid-frame too): tx=1, FSM=IDLE, FIFO empty, fifo_count=0, full=0, tbr=1, tx_idle=1, overflow=0, all counters 0. Any frame in progress is abandoned. tx goes high immediately.
- Push: accepted on a clk edge when wr_en=1 and full=0. full is sampled before that edge, so a push while full is rejected even if a pop happens in the same cycle.
- Rejected push: sets overflow. ovf_clr=1 clears it. If a rejected push and ovf_clr occur in the same cycle, set wins.
- Simultaneous push and pop when the FIFO is not full: fifo_count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when fifo_count>0, pop the head into the shift register and compute parity. If PARITY_ODD=1 the parity bit is ~^data, otherwise ^data. Go to START.
- Latency: a push at edge N into an empty FIFO makes fifo_count=1 after edge N. The pop happens at edge N+1, and tx=0 (start bit) after edge N+1.
- Bit period: a sub-counter counts `enable` pulses from 0 to OVERSAMPLE-1. The bit ends on the edge where enable=1 and the sub-counter equals OVERSAMPLE-1; the counter then returns to 0 and the next bit is driven after that edge. Cycles with enable=0 hold all timing state.
- START: drives 0 for one bit period, then goes to DATA.
- DATA: drives shreg[0] and shifts right at the end of each bit. A bit counter runs 0..DATA_BITS-1. After the last data bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: drives the stored parity bit for one bit period, then goes to STOP.
- STOP: drives 1 for STOP_BITS bit periods. At the end of the final stop bit:
  - if fifo_count>0, pop in the same edge and go straight to START (no idle gap);
  - otherwise go to IDLE.
- Frame length in bit periods: 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- tx is driven from a register that decodes the next state and bit, so it has no combinational glitches.
- Pushes are accepted at any time, including mid-frame. A push never disturbs the frame currently being sent.

Decomposition:
- Package spart_pkg holds:
  - typedef tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam helpers for counter widths ($clog2 of OVERSAMPLE, DATA_BITS, FIFO_DEPTH);
  - a parity function.
- One sub-module, spart_fifo, is parametrised by WIDTH and DEPTH. It provides push/pop ports plus full, empty and count, and is shared with the future receive path.
- Serialiser FSM, sub-counter and bit counter live in the top module.

Test Plan:
- Defaults with OVERSAMPLE=4 and enable tied high; push 0xA5 once -> tx after the pop reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 clk. tx_idle returns to 1 after 40 clk.
- PARITY_EN=1 and PARITY_ODD=0 (then PARITY_ODD=1); push 0xA5 -> parity bit 0 (then 1) appears after bit 7. With STOP_BITS=2 the frame is 12 bit periods.
- FIFO_DEPTH=4; push 5 words 0x01..0x05 on consecutive cycles while idle:
  - the first word is popped, so 4 remain queued and full=1 at the end;
  - the 5th push is accepted;
  - a 6th push gives overflow=1 and that word never appears on tx;
  - the frames go out back-to-back with no high gap between the stop bit and the next start bit.
- enable asserted 1 cycle in 3, OVERSAMPLE=16 -> each bit lasts exactly 48 clk. Stalling enable low for 100 clk mid-bit extends only that bit.
- Assert rst_n=0 during data bit 3 -> tx=1 within the same cycle. fifo_count=0 and overflow=0. After release, no residual frame is sent.
- Push and pop in the same cycle with fifo_count=2 -> count stays 2 and data order is preserved (FIFO).
- DATA_BITS=5: push 0x13 -> data bits 1,1,0,0,1 (LSB first), then 1 stop bit.
